// File: rtl/pc_pkg.sv
// pc_pkg
// Shared definitions for the fetch-stage program-counter generator.
// Holds the pc_control encodings used by decode/execute to choose the
// next fetch address. Codes 110 and 111 are unused and behave as SEQ.
package pc_pkg;

    localparam int PC_CTRL_W = 3;

    localparam logic [PC_CTRL_W-1:0] PC_SEQ    = 3'b000;
    localparam logic [PC_CTRL_W-1:0] PC_JUMP   = 3'b001;
    localparam logic [PC_CTRL_W-1:0] PC_JR     = 3'b010;
    localparam logic [PC_CTRL_W-1:0] PC_BRANCH = 3'b011;
    localparam logic [PC_CTRL_W-1:0] PC_CALL   = 3'b100;
    localparam logic [PC_CTRL_W-1:0] PC_RET    = 3'b101;

endpackage

// File: rtl/pc_ras.sv
// pc_ras
// Return-address stack kept as a circular buffer. top_ptr points at the
// most recent entry and count tracks occupancy (0..RAS_DEPTH). Pushing
// into a full stack overwrites the oldest entry, which is simply the slot
// after top_ptr once the buffer has wrapped; count then saturates.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   push       write push_data as the new top entry
//   push_data  return address to store
//   pop        drop the top entry (caller guarantees not empty)
//   top        current top entry (don't-care while empty)
//   empty      no entries held
//   full       RAS_DEPTH entries held
module pc_ras
    import pc_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] entries [RAS_DEPTH];
    logic [PTR_W-1:0]  top_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    assign wr_ptr = top_ptr + PTR_W'(1);
    assign top    = entries[top_ptr];
    assign empty  = (count == '0);
    assign full   = (count == FULL_CNT);

    // Pointer and occupancy. Reset parks top_ptr on the last slot so the
    // first push lands in slot 0; the pointer wraps naturally because the
    // depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            top_ptr <= '1;
            count   <= '0;
        end else if (push) begin
            top_ptr <= wr_ptr;
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop) begin
            top_ptr <= top_ptr - PTR_W'(1);
            count   <= count - CNT_W'(1);
        end
    end

    // Entry storage needs no reset: nothing is read while count is zero.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            entries[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen
// Fetch-stage program-counter generator. Selects the next fetch address
// from sequential, jump, register-jump, branch, call and return sources,
// with an exception redirect that overrides a stall.
// Build option: define PC_RAS_EN to build the return-address stack;
// without it CALL acts as JUMP, RET acts as JR, ras_hit is 0 and
// ras_empty is 1.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   stall          hold pc and RAS this cycle
//   exc_valid      redirect to EXC_VECTOR (wins over stall)
//   pc_control     next-PC select (see pc_pkg)
//   jump_address   J-type target field
//   branch_offset  signed word offset
//   reg_address    JR target and fallback for a return that misses the RAS
//   pc             current fetch address
//   link_pc        pc + 4 for the link register write
//   ras_hit        a return took its target from the RAS last edge
//   ras_empty      RAS holds no entries
//   addr_err       a JR/return target had nonzero low bits last edge
module pc_gen
    import pc_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(32'h0000_0080),
    parameter int                RAS_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 exc_valid,
    input  logic [PC_CTRL_W-1:0] pc_control,
    input  logic [25:0]          jump_address,
    input  logic [15:0]          branch_offset,
    input  logic [ADDR_W-1:0]    reg_address,
    output logic [ADDR_W-1:0]    pc,
    output logic [ADDR_W-1:0]    link_pc,
    output logic                 ras_hit,
    output logic                 ras_empty,
    output logic                 addr_err
);

    logic [ADDR_W-1:0] pc_plus_4;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] jr_target;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] pc_next;
    logic              hit_next;
    logic              err_next;

    assign pc_plus_4     = pc + ADDR_W'(4);
    assign link_pc       = pc_plus_4;
    assign jump_target   = {pc_plus_4[ADDR_W-1:28], jump_address, 2'b00};
    assign jr_target     = {reg_address[ADDR_W-1:2], 2'b00};
    assign branch_target = pc_plus_4
                         + {{(ADDR_W-18){branch_offset[15]}}, branch_offset, 2'b00};

`ifdef PC_RAS_EN
    logic              ras_push_req;
    logic              ras_pop_req;
    logic              ras_advance;
    logic [ADDR_W-1:0] ras_top;

    // The RAS only moves on a cycle where the pc itself advances.
    assign ras_advance = !exc_valid && !stall;

    pc_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push_req && ras_advance),
        .push_data (pc_plus_4),
        .pop       (ras_pop_req && ras_advance),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      ()
    );
`else
    assign ras_empty = 1'b1;
`endif

    // Next-PC selection. A return that finds the RAS empty falls back to
    // the register target and is the only return path that flags alignment.
    always_comb begin
        pc_next  = pc_plus_4;
        hit_next = 1'b0;
        err_next = 1'b0;
`ifdef PC_RAS_EN
        ras_push_req = 1'b0;
        ras_pop_req  = 1'b0;
`endif
        case (pc_control)
            PC_JUMP:   pc_next = jump_target;
            PC_BRANCH: pc_next = branch_target;
            PC_JR: begin
                pc_next  = jr_target;
                err_next = |reg_address[1:0];
            end
            PC_CALL: begin
                pc_next = jump_target;
`ifdef PC_RAS_EN
                ras_push_req = 1'b1;
`endif
            end
            PC_RET: begin
`ifdef PC_RAS_EN
                if (!ras_empty) begin
                    pc_next     = ras_top;
                    hit_next    = 1'b1;
                    ras_pop_req = 1'b1;
                end else begin
                    pc_next  = jr_target;
                    err_next = |reg_address[1:0];
                end
`else
                pc_next  = jr_target;
                err_next = |reg_address[1:0];
`endif
            end
            default:   pc_next = pc_plus_4;
        endcase
    end

    // PC and status flags. Priority is reset, exception, stall, then the
    // selected next-PC; the one-cycle flags clear whenever pc does not
    // take its normal next value.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            ras_hit  <= 1'b0;
            addr_err <= 1'b0;
        end else if (exc_valid) begin
            pc       <= EXC_VECTOR;
            ras_hit  <= 1'b0;
            addr_err <= 1'b0;
        end else if (stall) begin
            ras_hit  <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            pc       <= pc_next;
            ras_hit  <= hit_next;
            addr_err <= err_next;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen
// Testbench for pc_gen with default parameters. A behavioural model
// predicts each edge's outcome; predictions are queued when stimulus is
// driven and compared once the DUT has updated. Expectations follow the
// PC_RAS_EN build option.
module tb_pc_gen;
    import pc_pkg::*;

    localparam logic [31:0] RESET_PC   = 32'h0;
    localparam logic [31:0] EXC_VECTOR = 32'h80;
    localparam int          RAS_DEPTH  = 4;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        exc_valid;
    logic [2:0]  pc_control;
    logic [25:0] jump_address;
    logic [15:0] branch_offset;
    logic [31:0] reg_address;
    logic [31:0] pc;
    logic [31:0] link_pc;
    logic        ras_hit;
    logic        ras_empty;
    logic        addr_err;

    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic        empty;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mStack[$];
    logic [31:0] mPc;
    int          checks = 0;
    int          errors = 0;

    pc_gen #(
        .ADDR_W     (32),
        .RESET_PC   (RESET_PC),
        .EXC_VECTOR (EXC_VECTOR),
        .RAS_DEPTH  (RAS_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .exc_valid     (exc_valid),
        .pc_control    (pc_control),
        .jump_address  (jump_address),
        .branch_offset (branch_offset),
        .reg_address   (reg_address),
        .pc            (pc),
        .link_pc       (link_pc),
        .ras_hit       (ras_hit),
        .ras_empty     (ras_empty),
        .addr_err      (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Predict the effect of one edge from the inputs about to be sampled.
    task automatic modelStep(output exp_t e);
        logic [31:0] pp4;
        logic [31:0] jt;
        logic [31:0] jrt;
        logic        useRas;
        pp4 = mPc + 32'd4;
        jt  = {pp4[31:28], jump_address, 2'b00};
        jrt = {reg_address[31:2], 2'b00};
`ifdef PC_RAS_EN
        useRas = 1'b1;
`else
        useRas = 1'b0;
`endif
        e.hit = 1'b0;
        e.err = 1'b0;
        if (rst) begin
            mPc = RESET_PC;
            mStack.delete();
        end else if (exc_valid) begin
            mPc = EXC_VECTOR;
        end else if (!stall) begin
            case (pc_control)
                3'b001: mPc = jt;
                3'b010: begin mPc = jrt; e.err = |reg_address[1:0]; end
                3'b011: mPc = pp4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
                3'b100: begin
                    mPc = jt;
                    if (useRas) begin
                        mStack.push_back(pp4);
                        if (mStack.size() > RAS_DEPTH) void'(mStack.pop_front());
                    end
                end
                3'b101: begin
                    if (useRas && mStack.size() > 0) begin
                        mPc   = mStack.pop_back();
                        e.hit = 1'b1;
                    end else begin
                        mPc   = jrt;
                        e.err = |reg_address[1:0];
                    end
                end
                default: mPc = pp4;
            endcase
        end
        e.pc    = mPc;
        e.empty = (mStack.size() == 0);
    endtask

    // Drive one cycle of inputs, queue the prediction, then compare after
    // the edge.
    task automatic applyStimulus(input string tag, input logic r, input logic ex,
                                 input logic st, input logic [2:0] ctrl,
                                 input logic [25:0] ja, input logic [15:0] bo,
                                 input logic [31:0] ra);
        exp_t e;
        exp_t got;
        rst           = r;
        exc_valid     = ex;
        stall         = st;
        pc_control    = ctrl;
        jump_address  = ja;
        branch_offset = bo;
        reg_address   = ra;
        modelStep(e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        checkOutput({tag, ".pc"}, pc, got.pc);
        checkOutput({tag, ".link"}, link_pc, got.pc + 32'd4);
        checkOutput({tag, ".hit"}, {31'd0, ras_hit}, {31'd0, got.hit});
        checkOutput({tag, ".empty"}, {31'd0, ras_empty}, {31'd0, got.empty});
        checkOutput({tag, ".err"}, {31'd0, addr_err}, {31'd0, got.err});
    endtask

    initial begin
        mPc = 32'h0;
        rst = 1'b0; exc_valid = 1'b0; stall = 1'b0; pc_control = PC_SEQ;
        jump_address = '0; branch_offset = '0; reg_address = '0;
        @(posedge clk);
        #1;

        // Reset then sequential fetch with a stall.
        applyStimulus("reset", 1, 0, 0, PC_SEQ, 0, 0, 0);
        checkOutput("reset_pc_const", pc, 32'h0);
        applyStimulus("seq1", 0, 0, 0, PC_SEQ, 0, 0, 0);
        applyStimulus("seq2", 0, 0, 0, PC_SEQ, 0, 0, 0);
        applyStimulus("stall", 0, 0, 1, PC_SEQ, 0, 0, 0);
        checkOutput("stall_pc_const", pc, 32'h8);
        applyStimulus("seq3", 0, 0, 0, PC_SEQ, 0, 0, 0);

        // Jump and branch.
        applyStimulus("jr_setup", 0, 0, 0, PC_JR, 0, 0, 32'h1000_0010);
        applyStimulus("jump", 0, 0, 0, PC_JUMP, 26'h40, 0, 0);
        checkOutput("jump_pc_const", pc, 32'h1000_0100);
        applyStimulus("branch_m1", 0, 0, 0, PC_BRANCH, 0, 16'hFFFF, 0);
        applyStimulus("branch_p", 0, 0, 0, PC_BRANCH, 0, 16'h0010, 0);

        // Call and return.
        applyStimulus("jr_20", 0, 0, 0, PC_JR, 0, 0, 32'h20);
        applyStimulus("call", 0, 0, 0, PC_CALL, 26'h40, 0, 0);
        applyStimulus("ret1", 0, 0, 0, PC_RET, 0, 0, 32'h300);
        applyStimulus("ret2", 0, 0, 0, PC_RET, 0, 0, 32'h80);

        // RAS overflow: five calls then five returns.
        applyStimulus("jr_0", 0, 0, 0, PC_JR, 0, 0, 32'h0);
        for (int i = 1; i <= 5; i++)
            applyStimulus("ovf_call", 0, 0, 0, PC_CALL, 26'(i * 32'h40), 0, 0);
        for (int i = 0; i < 5; i++)
            applyStimulus("ovf_ret", 0, 0, 0, PC_RET, 0, 0, 32'h600);

        // Exception beats stall and call; RAS count is left alone.
        applyStimulus("pre_call", 0, 0, 0, PC_CALL, 26'h80, 0, 0);
        applyStimulus("exc", 0, 1, 1, PC_CALL, 26'h100, 0, 0);
        applyStimulus("stall_call", 0, 0, 1, PC_CALL, 26'h100, 0, 0);
        applyStimulus("ret_after_exc", 0, 0, 0, PC_RET, 0, 0, 32'h40);
        applyStimulus("ret_empty", 0, 0, 0, PC_RET, 0, 0, 32'h42);

        // Misaligned register jump, then the flag clears.
        applyStimulus("jr_mis", 0, 0, 0, PC_JR, 0, 0, 32'h0000_0103);
        applyStimulus("after_mis", 0, 0, 0, 3'b110, 0, 0, 0);
        applyStimulus("unused7", 0, 0, 0, 3'b111, 0, 0, 0);

        // Reset wins over a stalled call.
        applyStimulus("call_pre_rst", 0, 0, 0, PC_CALL, 26'h10, 0, 0);
        applyStimulus("rst_stall", 1, 0, 1, PC_CALL, 26'h10, 0, 0);

        // Random traffic against the model.
        for (int i = 0; i < 200; i++)
            applyStimulus("rand", 0, ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
                          26'($urandom), 16'($urandom), $urandom);

        checkOutput("sb_drain", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
